mul_hilo_ctrl: RTL and testbench

Sequencing and result-capture stage that sits directly upstream and downstream of the 2-stage pipelined 32-bit multiplier (`Mul`). It accepts an unsigned multiply issue from the datapath, holds the operands stable on the multiplier inputs, and tracks the fixed multiplier latency. It writes the 64-bit product into the architectural HI/LO registers and stalls HI/LO reads until the product lands. It also services direct HI/LO writes (MTHI/MTLO).

---
 rtl/mul_hilo_ctrl_if.sv | 33 +++
 rtl/mul_hilo_ctrl.sv | 76 +++++++
 tb/tb_mul_hilo_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mul_hilo_ctrl_if.sv
// Bundle between the issuing datapath, the pipelined multiplier and the
// HI/LO sequencing stage.
interface mul_hilo_ctrl_if #(
   parameter int WIDTH = 32
);
   logic                 start;
   logic [WIDTH-1:0]     op_a;
   logic [WIDTH-1:0]     op_b;
   logic                 mthi;
   logic                 mtlo;
   logic [WIDTH-1:0]     wr_data;
   logic                 rd_req;
   logic                 rd_sel;
   logic [2*WIDTH-1:0]   mul_y;
   logic [WIDTH-1:0]     mul_a;
   logic [WIDTH-1:0]     mul_b;
   logic                 ready;
   logic                 stall;
   logic [WIDTH-1:0]     rd_data;
   logic                 done;
   logic [WIDTH-1:0]     hi;
   logic [WIDTH-1:0]     lo;

   modport slave (
      input  start, op_a, op_b, mthi, mtlo, wr_data, rd_req, rd_sel, mul_y,
      output mul_a, mul_b, ready, stall, rd_data, done, hi, lo
   );

   modport master (
      output start, op_a, op_b, mthi, mtlo, wr_data, rd_req, rd_sel, mul_y,
      input  mul_a, mul_b, ready, stall, rd_data, done, hi, lo
   );
endinterface

// File: rtl/mul_hilo_ctrl.sv
// MULTU issue/writeback sequencer around a fixed-latency pipelined multiplier,
// owning the architectural HI/LO registers and MTHI/MTLO writes.
module mul_hilo_ctrl #(
   parameter int WIDTH   = 32,
   parameter int MUL_LAT = 2
) (
   input  logic           Clk,
   input  logic           Rst,
   mul_hilo_ctrl_if.slave bus
);
   localparam int CNT_W = $clog2(MUL_LAT + 2);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_d;
   logic [WIDTH-1:0]  mul_a_q;
   logic [WIDTH-1:0]  mul_b_q;
   logic [WIDTH-1:0]  hi_q;
   logic [WIDTH-1:0]  lo_q;
   logic              done_q;
   logic              busy;

   assign busy  = (state_q == BUSY);
   assign cnt_d = cnt_q - CNT_LAST;

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         mul_a_q <= '0;
         mul_b_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               // start wins over a same-cycle MTHI/MTLO, which is dropped
               if (bus.start) begin
                  mul_a_q <= bus.op_a;
                  mul_b_q <= bus.op_b;
                  cnt_q   <= CNT_LOAD;
                  state_q <= BUSY;
               end else begin
                  if (bus.mthi) hi_q <= bus.wr_data;
                  if (bus.mtlo) lo_q <= bus.wr_data;
               end
            end
            BUSY: begin
               cnt_q <= cnt_d;
               // product has cleared the multiplier pipeline
               if (cnt_q == CNT_LAST) begin
                  {hi_q, lo_q} <= bus.mul_y;
                  done_q       <= 1'b1;
                  state_q      <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.mul_a   = mul_a_q;
   assign bus.mul_b   = mul_b_q;
   assign bus.ready   = ~busy;
   assign bus.stall   = bus.rd_req & busy;
   assign bus.rd_data = bus.rd_sel ? hi_q : lo_q;
   assign bus.done    = done_q;
   assign bus.hi      = hi_q;
   assign bus.lo      = lo_q;
endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Directed bench for mul_hilo_ctrl with a 2-stage multiplier model and a
// product scoreboard drained on done.
module tb_mul_hilo_ctrl;
   logic Clk = 1'b0;
   logic Rst = 1'b0;
   int   total = 0;
   int   bad   = 0;
   logic [63:0] exp_q[$];

   mul_hilo_ctrl_if #(.WIDTH(32)) bus ();

   mul_hilo_ctrl #(.WIDTH(32), .MUL_LAT(2)) dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus)
   );

   always #5 Clk = ~Clk;

   // Mul: input registers then product register
   logic [31:0] ma_r, mb_r;
   logic [63:0] my_r;
   always_ff @(posedge Clk) begin
      ma_r <= bus.mul_a;
      mb_r <= bus.mul_b;
      my_r <= 64'(ma_r) * 64'(mb_r);
   end
   assign bus.mul_y = my_r;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   // scoreboard: every done must match the oldest outstanding product
   always @(negedge Clk) begin
      if (bus.done === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected_done", 64'd1, 64'd0);
         end else begin
            check("sb_product", {bus.hi, bus.lo}, exp_q.pop_front());
         end
      end
   end

   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         input bit rd, input logic [31:0] old_rd);
      logic [63:0] p;
      p = 64'(a) * 64'(b);
      bus.start = 1'b1;
      bus.op_a  = a;
      bus.op_b  = b;
      if (rd) begin
         bus.rd_req = 1'b1;
         bus.rd_sel = 1'b1;
      end
      exp_q.push_back(p);
      @(negedge Clk);
      check("ready_C", bus.ready, 1);
      if (rd) begin
         check("stall_C", bus.stall, 0);
         check("rd_old_C", bus.rd_data, old_rd);
      end
      step();
      bus.start = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         @(negedge Clk);
         check($sformatf("ready_busy_C%0d", k), bus.ready, 0);
         check($sformatf("done_busy_C%0d", k), bus.done, 0);
         check($sformatf("mul_a_C%0d", k), bus.mul_a, a);
         check($sformatf("mul_b_C%0d", k), bus.mul_b, b);
         if (rd) check($sformatf("stall_C%0d", k), bus.stall, 1);
         step();
      end
      @(negedge Clk);
      check("done_C4", bus.done, 1);
      check("ready_C4", bus.ready, 1);
      check("hilo_C4", {bus.hi, bus.lo}, p);
      if (rd) begin
         check("stall_C4", bus.stall, 0);
         check("rd_new_C4", bus.rd_data, p[63:32]);
      end
      step();
      bus.rd_req = 1'b0;
      bus.rd_sel = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.start = 0; bus.op_a = 0; bus.op_b = 0;
      bus.mthi = 0; bus.mtlo = 0; bus.wr_data = 0;
      bus.rd_req = 0; bus.rd_sel = 0;

      // reset
      Rst = 1'b0;
      step(); step();
      Rst = 1'b1;
      @(negedge Clk);
      check("rst_hi", bus.hi, 0);
      check("rst_lo", bus.lo, 0);
      check("rst_ready", bus.ready, 1);
      check("rst_done", bus.done, 0);
      check("rst_stall", bus.stall, 0);
      check("rst_rd_data", bus.rd_data, 0);
      step();

      // largest operands
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0);
      check("max_hi", bus.hi, 32'hFFFF_FFFE);
      check("max_lo", bus.lo, 32'h0000_0001);

      // read stall across the busy window
      run_op(32'h0001_0000, 32'h0001_0000, 1'b1, 32'hFFFF_FFFE);
      check("stall_op_lo", bus.lo, 32'h0);

      // MTHI+MTLO together in IDLE
      bus.mthi = 1; bus.mtlo = 1; bus.wr_data = 32'hA5A5_A5A5;
      step();
      bus.mthi = 0; bus.mtlo = 0;
      @(negedge Clk);
      check("mt_both_hi", bus.hi, 32'hA5A5_A5A5);
      check("mt_both_lo", bus.lo, 32'hA5A5_A5A5);

      // MTHI and second start during BUSY are ignored
      bus.start = 1; bus.op_a = 32'h0000_FFFF; bus.op_b = 32'h0001_0001;
      exp_q.push_back(64'h0000_0000_FFFF_FFFF);
      step();
      bus.start = 1; bus.op_a = 32'h1111_1111; bus.op_b = 32'h2222_2222;
      bus.mthi = 1; bus.wr_data = 32'h1234_5678;
      @(negedge Clk);
      check("busy_ready", bus.ready, 0);
      step();
      bus.start = 0; bus.mthi = 0;
      @(negedge Clk);
      check("busy_hold_a", bus.mul_a, 32'h0000_FFFF);
      check("busy_hi_kept", bus.hi, 32'hA5A5_A5A5);
      step();
      step();
      @(negedge Clk);
      check("busy_ign_done", bus.done, 1);
      check("busy_ign_hilo", {bus.hi, bus.lo}, 64'h0000_0000_FFFF_FFFF);
      step();
      @(negedge Clk);
      check("busy_ign_no_reissue", bus.ready, 1);
      step();

      // reset aborts an in-flight multiply
      bus.start = 1; bus.op_a = 7; bus.op_b = 6;
      step();
      bus.start = 0;
      step();
      Rst = 1'b0;
      exp_q.delete();
      step();
      Rst = 1'b1;
      @(negedge Clk);
      check("abort_ready", bus.ready, 1);
      check("abort_done", bus.done, 0);
      check("abort_hi", bus.hi, 0);
      check("abort_lo", bus.lo, 0);
      for (int k = 0; k < 4; k++) begin
         step();
         @(negedge Clk);
         check($sformatf("abort_quiet%0d", k), bus.done, 0);
      end
      step();
      run_op(32'd7, 32'd6, 1'b0, 32'h0);
      check("after_abort_lo", bus.lo, 32'd42);

      // start beats same-cycle MTLO
      bus.start = 1; bus.op_a = 3; bus.op_b = 5;
      bus.mtlo = 1; bus.wr_data = 32'h0000_DEAD;
      exp_q.push_back(64'd15);
      step();
      bus.start = 0; bus.mtlo = 0;
      @(negedge Clk);
      check("mtlo_dropped", bus.lo, 32'd42);
      step(); step();
      step();
      @(negedge Clk);
      check("prio_done", bus.done, 1);
      check("prio_lo", bus.lo, 32'd15);
      check("prio_hi", bus.hi, 32'd0);
      step();

      // single MTLO, one-cycle latency
      bus.mtlo = 1; bus.wr_data = 32'hCAFE_0001;
      step();
      bus.mtlo = 0;
      @(negedge Clk);
      check("mtlo_lo", bus.lo, 32'hCAFE_0001);
      check("mtlo_hi_kept", bus.hi, 32'd0);
      step();

      check("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
